round_unit: RTL and testbench
=============================

ROUND_UNIT -- requirements
Module: round_unit

Interface
REQ-001 Parameter MANT_W, default 24, mantissa width including hidden bit (>= 4).
REQ-002 Parameter EXP_W, default 8, biased exponent width (>= 2).
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 InValid  input  1  input beat valid.
REQ-006 InReady  output  1  unit can accept input this cycle.
REQ-007 Sign  input  1  operand sign.
REQ-008 Exp  input  EXP_W  biased exponent, pre-round.
REQ-009 Mant  input  MANT_W  normalised mantissa, pre-round; LSB is the least bit L.
REQ-010 GuardBit, RoundBit, StickyBit  input  1 each  first discarded bit, second discarded bit, OR of the remaining discarded bits.
REQ-011 Mode  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf).
REQ-012 OutValid  output  1  result valid.
REQ-013 OutReady  input  1  downstream accepts result.
REQ-014 OutSign, OutExp, OutMant  output  1 / EXP_W / MANT_W  rounded result.
REQ-015 Inexact, Overflow  output  1 each  status, aligned with the result.

Function
REQ-016 Increment decision: RNE = G&(L|R|S); RTZ = 0; RUP = !Sign&(G|R|S); RDN = Sign&(G|R|S).
REQ-017 Inexact SHALL equal G|R|S of the beat, except in the special bypass of REQ-021.
REQ-018 Stage 1 SHALL register Sign, Exp, Inexact and the MANT_W+1-bit sum Mant+increment.
REQ-019 Stage 2 SHALL renormalise: on carry-out, OutMant = 1 followed by MANT_W-1 zeros and OutExp = Exp+1; otherwise OutMant = the sum's low MANT_W bits and OutExp = Exp.
REQ-020 If the post-round exponent equals all-ones: Overflow=1, OutExp=all-ones, OutMant=0 (signed infinity), Inexact=1.
REQ-021 Input Exp all-ones (Inf/NaN) SHALL bypass rounding: Mant, Exp and Sign are passed unchanged, with Inexact=0 and Overflow=0.
REQ-022 Latency SHALL be exactly 2 cycles from input acceptance to OutValid when there is no backpressure; throughput 1 beat/cycle.
REQ-023 Input transfer SHALL occur when InValid&InReady; output transfer when OutValid&OutReady.
REQ-024 Stage 2 SHALL load when it is empty or OutReady=1; stage 1 SHALL load when it is empty or stage 2 loads.
REQ-025 InReady = !V1 | !V2 | OutReady. It is combinational from OutReady; no combinational path is permitted from InValid to InReady.
REQ-026 While OutValid=1 and OutReady=0, all outputs SHALL hold stable and no beat SHALL be lost or reordered.
REQ-027 Simultaneous input and output transfers SHALL be sustained with no bubble.

Reset
REQ-028 When Rst=1 at a clock edge: V1=V2=0, OutValid=0, OutSign=0, OutExp=0, OutMant=0, Inexact=0, Overflow=0.
REQ-029 InReady SHALL be 0 while Rst=1 and 1 in the first cycle after Rst is released.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; no result for them ever appears.

Configuration
REQ-031 Macro ROUND_UNIT_DIRECTED_MODES_EN defined: all four modes per REQ-016.
REQ-032 Macro undefined: Mode is ignored and RNE is always used; port list is unchanged.

Verification
REQ-033 MANT_W=24, EXP_W=8, RNE, Exp=0x7E, Mant=0xFFFFFF, G=1,R=0,S=0 -> after 2 cycles OutExp=0x7F, OutMant=0x800000, Inexact=1, Overflow=0.
REQ-034 RNE ties: Mant=0x800000, G=1,R=0,S=0 -> OutMant=0x800000; Mant=0x800001, same G/R/S -> OutMant=0x800002; both with Inexact=1.
REQ-035 Exp=0xFE, Mant=0xFFFFFF, G=1, RUP, Sign=0 -> OutExp=0xFF, OutMant=0, Overflow=1. Same beat with RTZ -> OutExp=0xFE, OutMant=0xFFFFFF, Overflow=0 (macro defined).
REQ-036 Stream 4 beats with OutReady=0 for 4 cycles -> exactly 2 accepted, InReady=0 afterwards, outputs stable. Release OutReady -> all 4 beats out in order, no duplicates.
REQ-037 Assert Rst for 1 cycle with both stages full -> next cycle OutValid=0, InReady=1, and no stale result is emitted later.
REQ-038 Exp=0xFF, Mant=0xC00000, G=1, RUP -> result identical to input, Inexact=0, Overflow=0.

Source files
------------

// File: rtl/round_unit.sv
// round_unit: two-stage floating-point rounding pipeline with valid/ready flow control.
// Stage 1 decides the increment and forms Mant+inc, and stage 2 renormalises and detects overflow.
// Inf/NaN operands (exponent all-ones) pass through without rounding.
// Optional feature macro: ROUND_UNIT_DIRECTED_MODES_EN.
// When it is defined, all four rounding modes are honoured.
// When it is undefined, Mode is ignored and round-to-nearest-even is always used.
module round_unit #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              InValid,
    output logic              InReady,
    input  logic              Sign,
    input  logic [EXP_W-1:0]  Exp,
    input  logic [MANT_W-1:0] Mant,
    input  logic              GuardBit,
    input  logic              RoundBit,
    input  logic              StickyBit,
    input  logic [1:0]        Mode,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutSign,
    output logic [EXP_W-1:0]  OutExp,
    output logic [MANT_W-1:0] OutMant,
    output logic              Inexact,
    output logic              Overflow
);

    localparam logic [1:0] MODE_RNE = 2'b00;
    localparam logic [1:0] MODE_RTZ = 2'b01;
    localparam logic [1:0] MODE_RUP = 2'b10;

    // stage 1 registers
    logic              v1_q, v1_d;
    logic              sign1_q, sign1_d;
    logic [EXP_W-1:0]  exp1_q, exp1_d;
    logic              inx1_q, inx1_d;
    logic              byp1_q, byp1_d;
    logic [MANT_W:0]   sum1_q, sum1_d;

    // stage 2 registers (drive the outputs directly)
    logic              v2_q, v2_d;
    logic              sign2_q, sign2_d;
    logic [EXP_W-1:0]  exp2_q, exp2_d;
    logic [MANT_W-1:0] mant2_q, mant2_d;
    logic              inx2_q, inx2_d;
    logic              ovf2_q, ovf2_d;

    logic load1, load2, in_fire;
    logic any_discard, bypass, inc;
    logic carry;
    logic [EXP_W-1:0]  r_exp;
    logic [MANT_W-1:0] r_mant;
    logic              r_inx, r_ovf;

`ifndef ROUND_UNIT_DIRECTED_MODES_EN
    logic unused_mode;
    assign unused_mode = ^Mode;
`endif

    // Flow control: a stage may load when it is empty or when the stage after it moves on.
    always_comb begin
        load2   = !v2_q || OutReady;
        load1   = !v1_q || load2;
        InReady = !Rst && load1;
        in_fire = InValid && InReady;
    end

    // Stage 1: make the increment decision and form the widened sum.
    always_comb begin
        any_discard = GuardBit | RoundBit | StickyBit;
        bypass      = &Exp;
`ifdef ROUND_UNIT_DIRECTED_MODES_EN
        unique case (Mode)
            MODE_RNE: inc = GuardBit & (Mant[0] | RoundBit | StickyBit);
            MODE_RTZ: inc = 1'b0;
            MODE_RUP: inc = !Sign & any_discard;
            default:  inc = Sign & any_discard;
        endcase
`else
        inc = GuardBit & (Mant[0] | RoundBit | StickyBit);
`endif
        v1_d    = load1 ? in_fire : v1_q;
        sign1_d = sign1_q;
        exp1_d  = exp1_q;
        inx1_d  = inx1_q;
        byp1_d  = byp1_q;
        sum1_d  = sum1_q;
        if (in_fire) begin
            sign1_d = Sign;
            exp1_d  = Exp;
            inx1_d  = any_discard & !bypass;
            byp1_d  = bypass;
            sum1_d  = {1'b0, Mant} + {{MANT_W{1'b0}}, inc & !bypass};
        end
    end

    // Stage 2: renormalise on carry-out and saturate an all-ones exponent to infinity.
    always_comb begin
        carry  = sum1_q[MANT_W];
        r_exp  = exp1_q;
        r_mant = sum1_q[MANT_W-1:0];
        r_inx  = inx1_q;
        r_ovf  = 1'b0;
        if (!byp1_q) begin
            if (carry) begin
                r_exp  = exp1_q + {{(EXP_W-1){1'b0}}, 1'b1};
                r_mant = {1'b1, {(MANT_W-1){1'b0}}};
            end
            if (&r_exp) begin
                r_mant = '0;
                r_inx  = 1'b1;
                r_ovf  = 1'b1;
            end
        end
        v2_d    = load2 ? v1_q : v2_q;
        sign2_d = sign2_q;
        exp2_d  = exp2_q;
        mant2_d = mant2_q;
        inx2_d  = inx2_q;
        ovf2_d  = ovf2_q;
        if (load2 && v1_q) begin
            sign2_d = sign1_q;
            exp2_d  = r_exp;
            mant2_d = r_mant;
            inx2_d  = r_inx;
            ovf2_d  = r_ovf;
        end
    end

    // Pipeline registers with synchronous reset that discards in-flight beats.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            exp1_q  <= '0;
            inx1_q  <= 1'b0;
            byp1_q  <= 1'b0;
            sum1_q  <= '0;
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            exp2_q  <= '0;
            mant2_q <= '0;
            inx2_q  <= 1'b0;
            ovf2_q  <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            sign1_q <= sign1_d;
            exp1_q  <= exp1_d;
            inx1_q  <= inx1_d;
            byp1_q  <= byp1_d;
            sum1_q  <= sum1_d;
            v2_q    <= v2_d;
            sign2_q <= sign2_d;
            exp2_q  <= exp2_d;
            mant2_q <= mant2_d;
            inx2_q  <= inx2_d;
            ovf2_q  <= ovf2_d;
        end
    end

    assign OutValid = v2_q;
    assign OutSign  = sign2_q;
    assign OutExp   = exp2_q;
    assign OutMant  = mant2_q;
    assign Inexact  = inx2_q;
    assign Overflow = ovf2_q;

endmodule

// File: tb/tb_round_unit.sv
// tb_round_unit: table-driven vectors plus a scoreboard queue, with hand-written
// sequences for latency, backpressure and mid-operation reset.
module tb_round_unit;

    localparam int MW = 24;
    localparam int EW = 8;
    localparam int NV = 16;

    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RUP = 2'b10;
    localparam logic [1:0] RDN = 2'b11;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          InValid = 1'b0;
    logic          InReady;
    logic          Sign = 1'b0;
    logic [EW-1:0] Exp = '0;
    logic [MW-1:0] Mant = '0;
    logic          GuardBit = 1'b0, RoundBit = 1'b0, StickyBit = 1'b0;
    logic [1:0]    Mode = 2'b00;
    logic          OutValid;
    logic          OutReady = 1'b0;
    logic          OutSign;
    logic [EW-1:0] OutExp;
    logic [MW-1:0] OutMant;
    logic          Inexact, Overflow;

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [MW-1:0] mant;
        logic          g, r, s;
        logic [1:0]    mode;
        logic [EW-1:0] e_exp;
        logic [MW-1:0] e_mant;
        logic          e_inx, e_ovf;
    } vec_t;

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [MW-1:0] mant;
        logic          inx, ovf;
    } res_t;

    vec_t vecs [NV];
    res_t sb_q [$];
    res_t got, expv, snap;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    round_unit #(.MANT_W(MW), .EXP_W(EW)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
        .Sign(Sign), .Exp(Exp), .Mant(Mant),
        .GuardBit(GuardBit), .RoundBit(RoundBit), .StickyBit(StickyBit),
        .Mode(Mode), .OutValid(OutValid), .OutReady(OutReady),
        .OutSign(OutSign), .OutExp(OutExp), .OutMant(OutMant),
        .Inexact(Inexact), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mk(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m,
                                input logic g, input logic r, input logic st, input logic [1:0] md,
                                input logic [EW-1:0] xe, input logic [MW-1:0] xm,
                                input logic xi, input logic xo);
        vec_t v;
        v.sign = s; v.exp = e; v.mant = m; v.g = g; v.r = r; v.s = st; v.mode = md;
        v.e_exp = xe; v.e_mant = xm; v.e_inx = xi; v.e_ovf = xo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Output monitor: every output transfer is compared against the oldest expected result.
    always @(negedge Clk) begin
        #2;
        if (!Rst && OutValid && OutReady) begin
            got = {OutSign, OutExp, OutMant, Inexact, Overflow};
            n_out++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0h with empty scoreboard", got);
            end else begin
                expv = sb_q.pop_front();
                if (got !== expv) begin
                    errors++;
                    $display("FAIL result: got sign=%0b exp=%0h mant=%0h inx=%0b ovf=%0b expected sign=%0b exp=%0h mant=%0h inx=%0b ovf=%0b",
                             got.sign, got.exp, got.mant, got.inx, got.ovf,
                             expv.sign, expv.exp, expv.mant, expv.inx, expv.ovf);
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        InValid = 1'b1; Sign = v.sign; Exp = v.exp; Mant = v.mant;
        GuardBit = v.g; RoundBit = v.r; StickyBit = v.s; Mode = v.mode;
    endtask

    task automatic push(input vec_t v);
        sb_q.push_back({v.sign, v.e_exp, v.e_mant, v.e_inx, v.e_ovf});
    endtask

    task automatic send(input vec_t v, output int stalls);
        stalls = 0;
        @(negedge Clk);
        drive(v);
        #1;
        while (!InReady && stalls < 50) begin
            @(negedge Clk);
            #1;
            stalls++;
        end
        if (!InReady) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: InReady stayed %0b, expected 1", InReady);
        end else begin
            push(v);
        end
        @(posedge Clk);
    endtask

    task automatic idle();
        @(negedge Clk);
        InValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || OutValid) && n < 100) begin
            @(negedge Clk);
            #3;
            n++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int st, stall_total, k, out_base;

        vecs[0]  = mk(0, 8'h7E, 24'hFFFFFF, 1, 0, 0, RNE, 8'h7F, 24'h800000, 1, 0);
        vecs[1]  = mk(0, 8'h80, 24'h800000, 1, 0, 0, RNE, 8'h80, 24'h800000, 1, 0);
        vecs[2]  = mk(0, 8'h80, 24'h800001, 1, 0, 0, RNE, 8'h80, 24'h800002, 1, 0);
        vecs[3]  = mk(1, 8'h40, 24'hABCDEF, 0, 0, 0, RNE, 8'h40, 24'hABCDEF, 0, 0);
        vecs[4]  = mk(0, 8'h55, 24'h800000, 1, 1, 0, RNE, 8'h55, 24'h800001, 1, 0);
        vecs[5]  = mk(1, 8'h55, 24'h800000, 0, 1, 1, RNE, 8'h55, 24'h800000, 1, 0);
        vecs[6]  = mk(1, 8'hFE, 24'hFFFFFF, 1, 0, 0, RNE, 8'hFF, 24'h000000, 1, 1);
        vecs[7]  = mk(0, 8'hFF, 24'hC00000, 1, 0, 0, RUP, 8'hFF, 24'hC00000, 0, 0);
        vecs[8]  = mk(0, 8'hFE, 24'hFFFFFF, 1, 0, 0, RUP, 8'hFF, 24'h000000, 1, 1);
`ifdef ROUND_UNIT_DIRECTED_MODES_EN
        vecs[9]  = mk(0, 8'hFE, 24'hFFFFFF, 1, 0, 0, RTZ, 8'hFE, 24'hFFFFFF, 1, 0);
        vecs[10] = mk(0, 8'h10, 24'h900000, 0, 0, 1, RUP, 8'h10, 24'h900001, 1, 0);
        vecs[11] = mk(1, 8'h10, 24'h900000, 0, 0, 1, RDN, 8'h10, 24'h900001, 1, 0);
        vecs[13] = mk(1, 8'h10, 24'h900000, 1, 1, 0, RUP, 8'h10, 24'h900000, 1, 0);
`else
        vecs[9]  = mk(0, 8'hFE, 24'hFFFFFF, 1, 0, 0, RTZ, 8'hFF, 24'h000000, 1, 1);
        vecs[10] = mk(0, 8'h10, 24'h900000, 0, 0, 1, RUP, 8'h10, 24'h900000, 1, 0);
        vecs[11] = mk(1, 8'h10, 24'h900000, 0, 0, 1, RDN, 8'h10, 24'h900000, 1, 0);
        vecs[13] = mk(1, 8'h10, 24'h900000, 1, 1, 0, RUP, 8'h10, 24'h900001, 1, 0);
`endif
        vecs[12] = mk(0, 8'h10, 24'h900000, 0, 0, 1, RDN, 8'h10, 24'h900000, 1, 0);
        vecs[14] = mk(1, 8'hFF, 24'h000000, 1, 1, 1, RNE, 8'hFF, 24'h000000, 0, 0);
        vecs[15] = mk(0, 8'hFD, 24'hFFFFFF, 1, 0, 0, RNE, 8'hFE, 24'h800000, 1, 0);

        // reset state
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_outvalid", 64'(OutValid), 64'd0);
        chk("rst_inready",  64'(InReady),  64'd0);
        chk("rst_outexp",   64'(OutExp),   64'd0);
        chk("rst_outmant",  64'(OutMant),  64'd0);
        chk("rst_flags",    64'({OutSign, Inexact, Overflow}), 64'd0);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("post_rst_inready", 64'(InReady), 64'd1);

        // two-cycle latency
        OutReady = 1'b1;
        send(vecs[0], st);
        @(negedge Clk);
        InValid = 1'b0;
        #1;
        chk("latency_cycle1", 64'(OutValid), 64'd0);
        @(negedge Clk);
        #1;
        chk("latency_cycle2", 64'(OutValid), 64'd1);
        drain();

        // full vector table, back to back
        stall_total = 0;
        for (int i = 0; i < NV; i++) begin
            send(vecs[i], st);
            stall_total += st;
        end
        idle();
        chk("stream_no_bubble", 64'(stall_total), 64'd0);
        drain();

        // backpressure: 4 beats offered while the sink is stalled
        out_base = n_out;
        @(negedge Clk);
        OutReady = 1'b0;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge Clk);
            drive(vecs[1 + k]);
            #1;
            if (c == 2) snap = {OutSign, OutExp, OutMant, Inexact, Overflow};
            if (InReady) begin
                push(vecs[1 + k]);
                k++;
            end
        end
        @(negedge Clk);
        InValid = 1'b0;
        #1;
        chk("bp_accepted", 64'(k), 64'd2);
        chk("bp_inready",  64'(InReady), 64'd0);
        chk("bp_outvalid", 64'(OutValid), 64'd1);
        chk("bp_stable",   64'({OutSign, OutExp, OutMant, Inexact, Overflow}), 64'(snap));
        OutReady = 1'b1;
        while (k < 4) begin
            send(vecs[1 + k], st);
            k++;
        end
        idle();
        drain();
        chk("bp_out_count", 64'(n_out - out_base), 64'd4);

        // reset with both stages full
        @(negedge Clk);
        OutReady = 1'b0;
        send(vecs[2], st);
        send(vecs[4], st);
        idle();
        @(negedge Clk);
        Rst = 1'b1;
        sb_q.delete();
        #1;
        chk("rst_mid_inready", 64'(InReady), 64'd0);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("rst_mid_outvalid", 64'(OutValid), 64'd0);
        chk("rst_mid_inready_after", 64'(InReady), 64'd1);
        out_base = n_out;
        OutReady = 1'b1;
        repeat (6) @(negedge Clk);
        #3;
        chk("rst_mid_no_stale", 64'(n_out - out_base), 64'd0);
        send(vecs[15], st);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
